// File: rtl/booth_div_pkg.sv
// Shared widths, FSM states and magnitude helpers for the sequential signed divider.
package booth_div_pkg;

    localparam int DW = 16;
    localparam int VW = 8;
    localparam int CW = 4;

    localparam logic [DW-1:0] Q_MAX     = 16'd127;
    localparam logic [DW-1:0] Q_MIN_MAG = 16'd128;

    typedef enum logic [1:0] {IDLE, DIV, FIX} state_t;

    // -32768 maps to 16'h8000, which is correct when read as unsigned.
    function automatic logic [DW-1:0] abs_dividend(input logic [DW-1:0] v);
        return v[DW-1] ? (~v + 1'b1) : v;
    endfunction

    function automatic logic [VW:0] abs_divisor(input logic [VW-1:0] v);
        logic [VW:0] ext;
        ext = {v[VW-1], v};
        return v[VW-1] ? (~ext + 1'b1) : ext;
    endfunction

endpackage

// File: rtl/booth_divider_if.sv
// Start/done handshake and result bus between the divider and its requester.
interface booth_divider_if;

    logic                           start;
    logic [booth_div_pkg::DW-1:0]   dividend;
    logic [booth_div_pkg::VW-1:0]   divisor;
    logic                           busy;
    logic                           done;
    logic [booth_div_pkg::VW-1:0]   quotient;
    logic [booth_div_pkg::VW-1:0]   remainder;
    logic                           overflow;
    logic                           div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, overflow, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, overflow, div_by_zero
    );

endinterface

// File: rtl/booth_divider_div_step.sv
// One restoring-division iteration: shift in a dividend bit, trial-subtract, restore on borrow.
module div_step
    import booth_div_pkg::*;
(
    input  logic [VW:0] rem_i,
    input  logic        bit_i,
    input  logic [VW:0] dvs_i,
    output logic [VW:0] rem_o,
    output logic        q_o
);

    logic [VW+1:0] shifted;
    logic [VW+1:0] trial;

    // rem_i never exceeds 127, so its top bit is always 0 and the shift cannot lose data.
    assign shifted = {rem_i, bit_i};
    assign trial   = shifted - {1'b0, dvs_i};
    assign q_o     = ~trial[VW+1];
    assign rem_o   = q_o ? trial[VW:0] : shifted[VW:0];

endmodule

// File: rtl/booth_divider.sv
// 16/8 signed truncating divider: restoring division on magnitudes, then sign fix-up.
// Define DIV_RADIX4_EN to retire two quotient bits per clock (9-clock latency instead of 17).
module booth_divider
    import booth_div_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    booth_divider_if.slave  bus
);

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [DW-1:0]   dvd_q, dvd_d;
    logic [VW:0]     dvs_q, dvs_d;
    logic [VW:0]     rem_q, rem_d;
    logic [DW-1:0]   qm_q, qm_d;
    logic            qneg_q, qneg_d, rneg_q, rneg_d, dz_q, dz_d;
    logic            busy_q, busy_d, done_q, done_d, ovf_q, ovf_d, dbz_q, dbz_d;
    logic [VW-1:0]   quo_q, quo_d, rmd_q, rmd_d;

    logic [VW:0]     rem_nxt;
    logic [DW-1:0]   qm_shift;
    logic [DW-1:0]   dvd_shift;

`ifdef DIV_RADIX4_EN
    localparam logic [CW-1:0] CNT_INIT = 4'd7;
    logic [VW:0] rem_mid;
    logic        q_hi, q_lo;

    div_step u_step_hi (.rem_i(rem_q),   .bit_i(dvd_q[DW-1]), .dvs_i(dvs_q), .rem_o(rem_mid), .q_o(q_hi));
    div_step u_step_lo (.rem_i(rem_mid), .bit_i(dvd_q[DW-2]), .dvs_i(dvs_q), .rem_o(rem_nxt), .q_o(q_lo));

    assign qm_shift  = {qm_q[DW-3:0], q_hi, q_lo};
    assign dvd_shift = {dvd_q[DW-3:0], 2'b00};
`else
    localparam logic [CW-1:0] CNT_INIT = 4'd15;
    logic q_bit;

    div_step u_step (.rem_i(rem_q), .bit_i(dvd_q[DW-1]), .dvs_i(dvs_q), .rem_o(rem_nxt), .q_o(q_bit));

    assign qm_shift  = {qm_q[DW-2:0], q_bit};
    assign dvd_shift = {dvd_q[DW-2:0], 1'b0};
`endif

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            rem_q   <= '0;
            qm_q    <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            dz_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
            dbz_q   <= 1'b0;
            quo_q   <= '0;
            rmd_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            rem_q   <= rem_d;
            qm_q    <= qm_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            dz_q    <= dz_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            ovf_q   <= ovf_d;
            dbz_q   <= dbz_d;
            quo_q   <= quo_d;
            rmd_q   <= rmd_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (bus.start) state_d = (bus.divisor == '0) ? FIX : DIV;
            DIV:     if (cnt_q == '0) state_d = FIX;
            FIX:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: every target gets a default first, so no path through the case can infer a latch.
    always_comb begin
        cnt_d  = cnt_q;
        dvd_d  = dvd_q;
        dvs_d  = dvs_q;
        rem_d  = rem_q;
        qm_d   = qm_q;
        qneg_d = qneg_q;
        rneg_d = rneg_q;
        dz_d   = dz_q;
        busy_d = busy_q;
        done_d = 1'b0;
        ovf_d  = ovf_q;
        dbz_d  = dbz_q;
        quo_d  = quo_q;
        rmd_d  = rmd_q;

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    busy_d = 1'b1;
                    ovf_d  = 1'b0;
                    dbz_d  = 1'b0;
                    qneg_d = bus.dividend[DW-1] ^ bus.divisor[VW-1];
                    rneg_d = bus.dividend[DW-1];
                    rem_d  = '0;
                    qm_d   = '0;
                    cnt_d  = CNT_INIT;
                    if (bus.divisor == '0) begin
                        dz_d  = 1'b1;
                        dvd_d = bus.dividend;
                    end else begin
                        dz_d  = 1'b0;
                        dvd_d = abs_dividend(bus.dividend);
                        dvs_d = abs_divisor(bus.divisor);
                    end
                end
            end
            DIV: begin
                rem_d = rem_nxt;
                qm_d  = qm_shift;
                dvd_d = dvd_shift;
                if (cnt_q != '0) cnt_d = cnt_q - 4'd1;
            end
            FIX: begin
                busy_d = 1'b0;
                done_d = 1'b1;
                if (dz_q) begin
                    quo_d = '0;
                    rmd_d = dvd_q[VW-1:0];
                    dbz_d = 1'b1;
                end else begin
                    rmd_d = rneg_q ? (8'd0 - rem_q[VW-1:0]) : rem_q[VW-1:0];
                    if (!qneg_q) begin
                        if (qm_q > Q_MAX) begin
                            quo_d = 8'h7F;
                            ovf_d = 1'b1;
                        end else begin
                            quo_d = qm_q[VW-1:0];
                        end
                    end else begin
                        if (qm_q > Q_MIN_MAG) begin
                            quo_d = 8'h80;
                            ovf_d = 1'b1;
                        end else begin
                            quo_d = 8'd0 - qm_q[VW-1:0];
                        end
                    end
                end
            end
            default: ;
        endcase
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.quotient    = quo_q;
    assign bus.remainder   = rmd_q;
    assign bus.overflow    = ovf_q;
    assign bus.div_by_zero = dbz_q;

endmodule
